mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_RD, default 2: read cycles with OE low (value 0 treated as 1).
REQ-002 SHALL have parameter WE_PULSE, default 3: write cycles with WE low (value 0 treated as 1).
REQ-003 SHALL have parameter WR_RECOVERY, default 8: EEPROM internal write-busy cycles after a write.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port r  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_rd  input  1: read request, level, held until ack.
REQ-007 SHALL have port req_wr  input  1: write request, level, held until ack.
REQ-008 SHALL have port req_addr  input  24: byte address from CPU addr; [23:22] selects bank a/b/c/d (0..3).
REQ-009 SHALL have port req_wdata  input  16: write data from CPU bus.
REQ-010 SHALL have port ack  output  1: one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  16: read data, valid while ack high, held until next read.
REQ-012 SHALL have port busy  output  1: high while FSM not IDLE or any bank recovering.
REQ-013 SHALL have port mem_addr  output  22: req_addr[21:0] to EEPROM array.
REQ-014 SHALL have port mem_dout  output  16: write data to EEPROM data pins.
REQ-015 SHALL have port mem_drive  output  1: high when mem_dout drives the data pins.
REQ-016 SHALL have port mem_din  input  16: data from EEPROM pins.
REQ-017 SHALL have ports epawe, epaoe, epbwe, epboe, epcwe, epcoe, epdwe, epdoe  output  1 each: active-low per-bank strobes.

Function
REQ-018 SHALL run FSM IDLE, SETUP, RD_WAIT, WR_PULSE, WR_HOLD; requests sampled only in IDLE.
REQ-019 SHALL, when req_rd and req_wr are both high in IDLE, serve the read; write stays pending.
REQ-020 SHALL latch address, data, direction and bank on the accepting edge; later input changes ignored until ack.
REQ-021 SHALL read as: SETUP 1 cycle (address valid, strobes high), RD_WAIT WAIT_RD cycles with selected OE low, capture mem_din on the edge ending RD_WAIT, ack high the next cycle in IDLE.
REQ-022 SHALL make read latency accept edge to ack rising = WAIT_RD+2 edges (4 at default).
REQ-023 SHALL write as: SETUP 1 cycle (mem_drive high, strobes high), WR_PULSE WE_PULSE cycles with selected WE low, WR_HOLD 1 cycle (WE high, mem_drive high), ack high in WR_HOLD.
REQ-024 SHALL, on leaving WR_HOLD, load a per-bank 8-bit recovery counter with WR_RECOVERY, decrementing each cycle to 0.
REQ-025 SHALL NOT accept any write, or a read to a bank with nonzero recovery counter, until that counter reaches 0; reads to other banks proceed.
REQ-026 SHALL drive all strobes from registers, glitch-free; at most one strobe low at any time; WE and OE never low together.
REQ-027 SHALL keep mem_drive low in all read states and IDLE; mem_addr stable from SETUP through last state of the access.
REQ-028 SHALL issue exactly one ack per accepted request; no ack for unaccepted requests.

Reset
REQ-029 SHALL, while r low, force asynchronously: FSM IDLE, all eight strobes 1, ack 0, busy 0, mem_drive 0, rdata 0, mem_addr 0, mem_dout 0, recovery counters 0.
REQ-030 SHALL abort an in-flight access on reset, WE/OE returning high immediately without waiting for a clock; no ack for it.
REQ-031 SHALL sample requests on the first rising edge with r high.

Verification
REQ-032 SHALL cover read: req_rd, addr 0x400010, mem_din 0xBEEF -> epboe low 2 cycles, ack on edge 4, rdata 0xBEEF, others high.
REQ-033 SHALL cover write: req_wr, addr 0xC00002, wdata 0x1234 -> epdwe low 3 cycles, mem_dout 0x1234, mem_drive high SETUP..WR_HOLD, ack in WR_HOLD, busy high 8 more cycles.
REQ-034 SHALL cover recovery: write bank a then read bank a -> read waits 8 cycles; read bank c right after -> starts immediately.
REQ-035 SHALL cover simultaneous: req_rd and req_wr high in IDLE -> read served first, write accepted after read ack, two acks.
REQ-036 SHALL cover mid-write reset: r low during WR_PULSE -> epawe high same time step, no ack, all outputs reset values.
REQ-037 SHALL assert throughout all scenarios: never more than one strobe low, never ack without prior accepted request.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// EEPROM bus controller: turns level read/write requests into per-bank strobe sequences,
// and applies a per-bank write-recovery lockout after each write.
module mem_bus_ctrl #(
    parameter int WAIT_RD     = 2,
    parameter int WE_PULSE    = 3,
    parameter int WR_RECOVERY = 8
) (
    input  logic        clk,
    input  logic        r,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic        mem_drive,
    input  logic [15:0] mem_din,
    output logic        epawe,
    output logic        epaoe,
    output logic        epbwe,
    output logic        epboe,
    output logic        epcwe,
    output logic        epcoe,
    output logic        epdwe,
    output logic        epdoe
);

    localparam int unsigned RD_CYC = (WAIT_RD < 1) ? 1 : WAIT_RD;
    localparam int unsigned WP_CYC = (WE_PULSE < 1) ? 1 : WE_PULSE;

    typedef enum logic [2:0] {IDLE, SETUP, RD_WAIT, WR_PULSE, WR_HOLD} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [1:0]  r_bank;
    logic        r_is_wr;
    logic [7:0]  r_rec [4];
    logic [3:0]  r_we_n, r_oe_n;
    logic        r_ack;
    logic [15:0] r_rdata;
    logic [21:0] r_addr;
    logic [15:0] r_dout;
    logic        r_drive;

    logic        w_rec_any, w_rd_free, w_acc_rd, w_acc_wr, w_rd_last, w_wp_last;
    logic [3:0]  w_bank_sel;

    assign w_rec_any  = (r_rec[0] != 8'd0) || (r_rec[1] != 8'd0) ||
                        (r_rec[2] != 8'd0) || (r_rec[3] != 8'd0);
    assign w_rd_free  = (r_rec[req_addr[23:22]] == 8'd0);
    // No acceptance during the read-ack cycle, so a requester that drops its level on seeing ack is not served twice.
    assign w_acc_rd   = (r_state == IDLE) && !r_ack && req_rd && w_rd_free;
    assign w_acc_wr   = (r_state == IDLE) && !r_ack && !w_acc_rd && req_wr && !w_rec_any;
    assign w_rd_last  = (r_cnt == 16'(RD_CYC - 1));
    assign w_wp_last  = (r_cnt == 16'(WP_CYC - 1));
    assign w_bank_sel = 4'b0001 << r_bank;

    always_ff @(posedge clk or negedge r) begin
        if (!r) r_state <= IDLE;
        else    r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_acc_rd || w_acc_wr) w_next = SETUP;
            SETUP:    w_next = r_is_wr ? WR_PULSE : RD_WAIT;
            RD_WAIT:  if (w_rd_last) w_next = IDLE;
            WR_PULSE: if (w_wp_last) w_next = WR_HOLD;
            WR_HOLD:  w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Strobes, ack and drive enable are registered from the next state so the pins never glitch.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_cnt   <= '0;
            r_bank  <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_we_n  <= 4'hF;
            r_oe_n  <= 4'hF;
            r_drive <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            if (w_acc_rd || w_acc_wr) begin
                r_addr  <= req_addr[21:0];
                r_bank  <= req_addr[23:22];
                r_is_wr <= w_acc_wr;
            end
            if (w_acc_wr) r_dout <= req_wdata;
            if (r_state == RD_WAIT && w_rd_last) r_rdata <= mem_din;
            r_ack   <= (r_state == RD_WAIT && w_rd_last) || (r_state == WR_PULSE && w_wp_last);
            r_we_n  <= (w_next == WR_PULSE) ? ~w_bank_sel : 4'hF;
            r_oe_n  <= (w_next == RD_WAIT)  ? ~w_bank_sel : 4'hF;
            r_drive <= (w_next == SETUP && w_acc_wr) || (w_next == WR_PULSE) || (w_next == WR_HOLD);
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < 4; i++) r_rec[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_state == WR_HOLD && r_bank == 2'(i)) r_rec[i] <= 8'(WR_RECOVERY);
                else if (r_rec[i] != 8'd0)                 r_rec[i] <= r_rec[i] - 8'd1;
            end
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE) || w_rec_any;
    assign mem_addr  = r_addr;
    assign mem_dout  = r_dout;
    assign mem_drive = r_drive;
    assign epawe     = r_we_n[0];
    assign epaoe     = r_oe_n[0];
    assign epbwe     = r_we_n[1];
    assign epboe     = r_oe_n[1];
    assign epcwe     = r_we_n[2];
    assign epcoe     = r_oe_n[2];
    assign epdwe     = r_we_n[3];
    assign epdoe     = r_oe_n[3];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scenario bench for mem_bus_ctrl: per-feature tasks plus a scoreboard of expected acks
// and a monitor enforcing the single-strobe rule.
module tb_mem_bus_ctrl;

    localparam int WAIT_RD     = 2;
    localparam int WE_PULSE    = 3;
    localparam int WR_RECOVERY = 8;

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] mem_din = '0;
    logic        ack, busy, mem_drive;
    logic [15:0] rdata, mem_dout;
    logic [21:0] mem_addr;
    logic        epawe, epaoe, epbwe, epboe, epcwe, epcoe, epdwe, epdoe;
    logic [7:0]  strobes;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails = 0;

    mem_bus_ctrl #(.WAIT_RD(WAIT_RD), .WE_PULSE(WE_PULSE), .WR_RECOVERY(WR_RECOVERY)) dut (
        .clk(clk), .r(r), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_drive(mem_drive), .mem_din(mem_din),
        .epawe(epawe), .epaoe(epaoe), .epbwe(epbwe), .epboe(epboe),
        .epcwe(epcwe), .epcoe(epcoe), .epdwe(epdwe), .epdoe(epdoe)
    );

    assign strobes = {epawe, epaoe, epbwe, epboe, epcwe, epcoe, epdwe, epdoe};

    always #5 clk = ~clk;

    // Each ack must match the oldest outstanding expectation; reads carry their data.
    always @(negedge clk) begin
        if (r === 1'b1) begin
            n_checks++;
            if ($countones(~strobes) > 1) begin
                n_fails++;
                $display("[TB] FAIL strobe_onehot: strobes=%b, required at most one low", strobes);
            end
            if (ack === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL ack_unexpected: ack=1 with no accepted request, required ack=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mem_drive !== !mon_e.is_rd) begin
                        n_fails++;
                        $display("[TB] FAIL ack_kind: mem_drive=%b at ack, required %b", mem_drive, !mon_e.is_rd);
                    end
                    if (mon_e.is_rd && rdata !== mon_e.rdata) begin
                        n_fails++;
                        $display("[TB] FAIL ack_rdata: rdata=%h, required %h", rdata, mon_e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until ack is seen, or -1 if the bound expires.
    task automatic wait_ack(input int limit, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (ack !== 1'b1 && edges < limit);
        if (ack !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        r = 1'b0;
        req_rd = 1'b1;
        req_addr = 24'h400010;
        repeat (2) @(posedge clk);
        #3;
        n_checks++; if (strobes !== 8'hFF) begin n_fails++; $display("[TB] FAIL rst_strobes: got %b, required 11111111", strobes); end
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_ack: got %b, required 0", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (mem_drive !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_drive: got %b, required 0", mem_drive); end
        n_checks++; if (rdata !== 16'h0) begin n_fails++; $display("[TB] FAIL rst_rdata: got %h, required 0000", rdata); end
        n_checks++; if (mem_addr !== 22'h0) begin n_fails++; $display("[TB] FAIL rst_addr: got %h, required 000000", mem_addr); end
        n_checks++; if (mem_dout !== 16'h0) begin n_fails++; $display("[TB] FAIL rst_dout: got %h, required 0000", mem_dout); end
        req_rd = 1'b0;
        tick();
        r = 1'b1;
    endtask

    task automatic test_read();
        int edges = 0;
        int oe_low = 0;
        int other_low = 0;
        int drive_hi = 0;
        mem_din = 16'hBEEF;
        req_addr = 24'h400010;
        req_rd = 1'b1;
        exp_q.push_back({1'b1, 16'hBEEF});
        do begin
            tick();
            edges++;
            if (edges == 1) req_addr = 24'hFFFFFF;
            if (epboe === 1'b0) oe_low++;
            if (((~strobes) & 8'hEF) != 8'h00) other_low++;
            if (mem_drive !== 1'b0) drive_hi++;
        end while (ack !== 1'b1 && edges < 20);
        req_rd = 1'b0;
        n_checks++; if (edges != WAIT_RD + 2) begin n_fails++; $display("[TB] FAIL rd_latency: got %0d edges, required %0d", edges, WAIT_RD + 2); end
        n_checks++; if (oe_low != WAIT_RD) begin n_fails++; $display("[TB] FAIL rd_oe_width: got %0d cycles, required %0d", oe_low, WAIT_RD); end
        n_checks++; if (other_low != 0) begin n_fails++; $display("[TB] FAIL rd_other_strobes: got %0d cycles low, required 0", other_low); end
        n_checks++; if (drive_hi != 0) begin n_fails++; $display("[TB] FAIL rd_drive: got %0d cycles high, required 0", drive_hi); end
        n_checks++; if (mem_addr !== 22'h000010) begin n_fails++; $display("[TB] FAIL rd_addr_latch: got %h, required 000010", mem_addr); end
        mem_din = 16'h0000;
        tick();
        n_checks++; if (rdata !== 16'hBEEF) begin n_fails++; $display("[TB] FAIL rd_hold: got %h, required beef", rdata); end
    endtask

    task automatic test_write();
        int edges = 0;
        int we_low = 0;
        int other_low = 0;
        int drive_hi = 0;
        int busy_cnt = 0;
        req_addr = 24'hC00002;
        req_wdata = 16'h1234;
        req_wr = 1'b1;
        exp_q.push_back({1'b0, 16'h0000});
        do begin
            tick();
            edges++;
            if (edges == 1) req_wdata = 16'hFFFF;
            if (epdwe === 1'b0) we_low++;
            if (((~strobes) & 8'hFD) != 8'h00) other_low++;
            if (mem_drive === 1'b1) drive_hi++;
        end while (ack !== 1'b1 && edges < 20);
        req_wr = 1'b0;
        n_checks++; if (edges != WE_PULSE + 2) begin n_fails++; $display("[TB] FAIL wr_latency: got %0d edges, required %0d", edges, WE_PULSE + 2); end
        n_checks++; if (we_low != WE_PULSE) begin n_fails++; $display("[TB] FAIL wr_we_width: got %0d cycles, required %0d", we_low, WE_PULSE); end
        n_checks++; if (other_low != 0) begin n_fails++; $display("[TB] FAIL wr_other_strobes: got %0d cycles low, required 0", other_low); end
        n_checks++; if (drive_hi != WE_PULSE + 2) begin n_fails++; $display("[TB] FAIL wr_drive: got %0d cycles high, required %0d", drive_hi, WE_PULSE + 2); end
        n_checks++; if (mem_dout !== 16'h1234) begin n_fails++; $display("[TB] FAIL wr_dout: got %h, required 1234", mem_dout); end
        n_checks++; if (mem_addr !== 22'h000002) begin n_fails++; $display("[TB] FAIL wr_addr: got %h, required 000002", mem_addr); end
        tick();
        n_checks++; if (mem_drive !== 1'b0) begin n_fails++; $display("[TB] FAIL wr_drive_release: got %b, required 0", mem_drive); end
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && busy_cnt < 50) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++; if (busy_cnt != WR_RECOVERY) begin n_fails++; $display("[TB] FAIL wr_recovery_busy: got %0d cycles, required %0d", busy_cnt, WR_RECOVERY); end
    endtask

    task automatic test_recovery();
        int edges;
        int guard;
        req_addr = 24'h000100;
        req_wdata = 16'hA5A5;
        req_wr = 1'b1;
        exp_q.push_back({1'b0, 16'h0000});
        wait_ack(20, edges);
        req_wr = 1'b0;
        n_checks++; if (edges != WE_PULSE + 2) begin n_fails++; $display("[TB] FAIL rec_wr_latency: got %0d, required %0d", edges, WE_PULSE + 2); end
        mem_din = 16'h7777;
        req_addr = 24'h000104;
        req_rd = 1'b1;
        exp_q.push_back({1'b1, 16'h7777});
        wait_ack(40, edges);
        req_rd = 1'b0;
        n_checks++; if (edges != 1 + WR_RECOVERY + WAIT_RD + 2) begin n_fails++; $display("[TB] FAIL rec_same_bank: got %0d edges, required %0d", edges, 1 + WR_RECOVERY + WAIT_RD + 2); end
        req_addr = 24'h000200;
        req_wdata = 16'h0F0F;
        req_wr = 1'b1;
        exp_q.push_back({1'b0, 16'h0000});
        wait_ack(20, edges);
        req_wr = 1'b0;
        mem_din = 16'hC0DE;
        req_addr = 24'h800008;
        req_rd = 1'b1;
        exp_q.push_back({1'b1, 16'hC0DE});
        wait_ack(40, edges);
        req_rd = 1'b0;
        n_checks++; if (edges != 1 + WAIT_RD + 2) begin n_fails++; $display("[TB] FAIL rec_other_bank: got %0d edges, required %0d", edges, 1 + WAIT_RD + 2); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL rec_busy_during: got %b, required 1", busy); end
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin tick(); guard++; end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rec_busy_clear: got %b, required 0", busy); end
    endtask

    task automatic test_simultaneous();
        int edges;
        int guard;
        mem_din = 16'h1111;
        req_addr = 24'h400020;
        req_wdata = 16'h5A5A;
        exp_q.push_back({1'b1, 16'h1111});
        exp_q.push_back({1'b0, 16'h0000});
        req_rd = 1'b1;
        req_wr = 1'b1;
        wait_ack(20, edges);
        req_rd = 1'b0;
        n_checks++; if (edges != WAIT_RD + 2) begin n_fails++; $display("[TB] FAIL sim_read_first: got %0d edges, required %0d", edges, WAIT_RD + 2); end
        wait_ack(30, edges);
        req_wr = 1'b0;
        n_checks++; if (edges < 0) begin n_fails++; $display("[TB] FAIL sim_write_ack: got timeout, required ack"); end
        n_checks++; if (mem_dout !== 16'h5A5A) begin n_fails++; $display("[TB] FAIL sim_write_data: got %h, required 5a5a", mem_dout); end
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin tick(); guard++; end
    endtask

    task automatic test_mid_write_reset();
        int guard = 0;
        int edges;
        req_addr = 24'h000040;
        req_wdata = 16'hDEAD;
        req_wr = 1'b1;
        do begin
            tick();
            guard++;
        end while (epawe !== 1'b0 && guard < 20);
        n_checks++; if (epawe !== 1'b0) begin n_fails++; $display("[TB] FAIL mwr_pulse_seen: epawe=%b, required 0", epawe); end
        #2;
        r = 1'b0;
        #1;
        n_checks++; if (epawe !== 1'b1) begin n_fails++; $display("[TB] FAIL mwr_we_release: got %b, required 1", epawe); end
        n_checks++; if (strobes !== 8'hFF) begin n_fails++; $display("[TB] FAIL mwr_strobes: got %b, required 11111111", strobes); end
        n_checks++; if (mem_drive !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin n_fails++; $display("[TB] FAIL mwr_ctrl: drive=%b busy=%b ack=%b, required 0 0 0", mem_drive, busy, ack); end
        n_checks++; if (mem_addr !== 22'h0 || mem_dout !== 16'h0 || rdata !== 16'h0) begin n_fails++; $display("[TB] FAIL mwr_data: addr=%h dout=%h rdata=%h, required 0", mem_addr, mem_dout, rdata); end
        req_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ack !== 1'b0) begin n_fails++; $display("[TB] FAIL mwr_no_ack: got %b, required 0", ack); end
        r = 1'b1;
        mem_din = 16'h3C3C;
        req_addr = 24'h000050;
        req_rd = 1'b1;
        exp_q.push_back({1'b1, 16'h3C3C});
        wait_ack(20, edges);
        req_rd = 1'b0;
        n_checks++; if (edges != WAIT_RD + 2) begin n_fails++; $display("[TB] FAIL mwr_first_edge: got %0d edges, required %0d", edges, WAIT_RD + 2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_recovery();
        test_simultaneous();
        test_mid_write_reset();
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL acks_outstanding: got %0d missing acks, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
